pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//  Parametrised, pipelined ripple-carry adder/subtractor; successor to the fixed 8-bit
//  full-adder chain. Splits WIDTH into SEG_W-bit segments, one per pipeline stage, with
//  the carry registered between stages. Valid/ready streaming on both sides;
//  1 result/cycle sustained. Arithmetic unit for the datapath.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; must be a multiple of SEG_W
//  SEG_W    8  bits added per stage; STAGES = WIDTH/SEG_W (>=1)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      adder can accept a beat this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry-in (add mode only)
//  in_sub     in   1      0: A+B+cin; 1: A-B (cin ignored)
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts result
//  out_sum    out  WIDTH  result
//  out_cout   out  1      carry-out of MSB (sub: 1 = no borrow)
//  out_ovf    out  1      two's-complement signed overflow
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valid bits, carries, partial sums,
//    out_sum, out_cout, out_ovf, out_valid = 0. in_ready = 1 from first cycle after reset.
//  - Transfer on input when in_valid & in_ready; on output when out_valid & out_ready.
//  - Operand prep at accept: B' = in_sub ? ~in_b : in_b; c0 = in_sub ? 1 : in_cin.
//  - Stage k (0..STAGES-1) adds segment k of A and B' plus incoming carry; registers
//    sum bits [k*SEG_W +: SEG_W], carry, and the not-yet-added operand bits.
//  - Latency: result valid exactly STAGES cycles after input accept when unstalled.
//  - Per-stage register holds a beat and valid bit. stage_ready[k] = ~valid[k] |
//    stage_ready[k+1]; stage_ready[STAGES] = out_ready. in_ready = stage_ready[0].
//    A stage loads only when its ready is high; bubbles collapse under backpressure.
//  - Stalled beats hold all fields stable; out_sum/out_cout/out_ovf stable while
//    out_valid & ~out_ready. No beat dropped, duplicated or reordered.
//  - Simultaneous accept and output with pipeline full: allowed (ready chain is
//    combinational through), throughput stays 1/cycle.
//  - out_cout = carry out of bit WIDTH-1. out_ovf = carry into MSB XOR carry out of MSB.
//  - Sum wraps modulo 2^WIDTH; no saturation.
//  - Reset mid-operation: all in-flight beats discarded; no out_valid until a new beat
//    is accepted and STAGES cycles elapse.
//  - STAGES = 1: degenerates to a single registered adder with skid-free ready.
// TESTING (WIDTH=16, SEG_W=4, STAGES=4)
//  1. a=0x1234 b=0x0FFF cin=1 sub=0, out_ready=1 -> 4 cycles later sum=0x2234 cout=0 ovf=0
//  2. a=0xFFFF b=0x0000 cin=1 -> carry ripples all stages: sum=0x0000 cout=1 ovf=0;
//     a=0x7FFF b=0x0001 cin=0 -> sum=0x8000 cout=0 ovf=1
//  3. sub=1 a=0x0005 b=0x0007 -> sum=0xFFFE cout=0; a=0x8000 b=0x0001 -> sum=0x7FFF ovf=1
//  4. 8 back-to-back beats, out_ready low cycles 3-5 -> in_ready drops once 4 stages
//     full; all 8 results in order, held stable while stalled, none lost
//  5. 100 random beats, random in_valid/out_ready -> every result matches golden model;
//     full-rate stretch yields 1 result/cycle
//  6. rst pulsed with 3 beats in flight -> outputs 0, out_valid=0, in_ready=1 next cycle;
//     next beat emerges exactly 4 cycles after accept

Source files
------------

// File: rtl/pipelined_adder_if.sv
// Streaming operand/result bundle for pipelined_adder.
// master drives operands and accepts results; slave is the adder.
interface pipelined_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: one SEG_W-bit segment per stage,
// carry registered between stages, valid/ready flow control with collapsing bubbles.
module pipelined_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    pipelined_adder_if.slave bus
);
    localparam int unsigned STAGES = WIDTH / SEG_W;

    // Stage registers: operands carried forward, partial sum, carry out of the segment.
    logic [STAGES-1:0] valid;
    logic [WIDTH-1:0]  a_r [STAGES];
    logic [WIDTH-1:0]  b_r [STAGES];
    logic [WIDTH-1:0]  s_r [STAGES];
    logic [STAGES-1:0] c_r;
    logic              ovf_r;

    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_s [STAGES];
    logic [SEG_W:0]    seg   [STAGES];
    logic [WIDTH-1:0]  nxt_s [STAGES];
    logic              nxt_ovf;

    // rdy[k] = ~valid[k] | rdy[k+1], unrolled as "out_ready or a hole at/after k"
    // so the chain has no self-referencing combinational vector.
    always_comb begin : ready_chain
        logic full;
        full = 1'b1;
        rdy  = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            full                = full & valid[STAGES-1-i];
            rdy[STAGES-1-i]     = bus.out_ready | ~full;
        end
    end

    always_comb begin
        src_v[0] = bus.in_valid;
        src_a[0] = bus.in_a;
        src_b[0] = bus.in_sub ? ~bus.in_b : bus.in_b;
        src_c[0] = bus.in_sub | bus.in_cin;
        src_s[0] = '0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_v[k] = valid[k-1];
            src_a[k] = a_r[k-1];
            src_b[k] = b_r[k-1];
            src_c[k] = c_r[k-1];
            src_s[k] = s_r[k-1];
        end
        for (int unsigned k = 0; k < STAGES; k++) begin
            seg[k]   = {1'b0, src_a[k][k*SEG_W +: SEG_W]}
                     + {1'b0, src_b[k][k*SEG_W +: SEG_W]}
                     + {{SEG_W{1'b0}}, src_c[k]};
            nxt_s[k] = src_s[k];
            nxt_s[k][k*SEG_W +: SEG_W] = seg[k][SEG_W-1:0];
        end
        // carry into the MSB is recovered as a^b^sum at that bit
        nxt_ovf = src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1]
                ^ seg[STAGES-1][SEG_W-1] ^ seg[STAGES-1][SEG_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            c_r   <= '0;
            ovf_r <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_r[k] <= '0;
                b_r[k] <= '0;
                s_r[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    valid[k] <= src_v[k];
                    if (src_v[k]) begin
                        a_r[k] <= src_a[k];
                        b_r[k] <= src_b[k];
                        s_r[k] <= nxt_s[k];
                        c_r[k] <= seg[k][SEG_W];
                    end
                end
            end
            if (rdy[STAGES-1] && src_v[STAGES-1]) begin
                ovf_r <= nxt_ovf;
            end
        end
    end

    always_comb begin
        bus.in_ready  = rdy[0];
        bus.out_valid = valid[STAGES-1];
        bus.out_sum   = s_r[STAGES-1];
        bus.out_cout  = c_r[STAGES-1];
        bus.out_ovf   = ovf_r;
    end
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder at WIDTH=16, SEG_W=4 (4 stages).
module tb_pipelined_adder;
    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int unsigned acc;
        bit          latchk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned rdy_mode = 0;
    int unsigned s0 = 0;
    bit          saw_low = 1'b0;
    exp_t        sbq [$];
    int unsigned pop_cyc [$];

    pipelined_adder_if #(.WIDTH(16)) bif ();

    pipelined_adder #(.WIDTH(16), .SEG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        exp_t        m;
        logic [15:0] bb;
        logic [16:0] full;
        bb       = sub ? ~b : b;
        full     = {1'b0, a} + {1'b0, bb} + {16'd0, (sub | cin)};
        m.sum    = full[15:0];
        m.cout   = full[16];
        m.ovf    = (a[15] == bb[15]) && (full[15] != a[15]);
        m.acc    = 0;
        m.latchk = 1'b0;
        return m;
    endfunction

    function automatic exp_t mk(input logic [15:0] s, input logic c, input logic o);
        exp_t m;
        m.sum = s; m.cout = c; m.ovf = o; m.acc = 0; m.latchk = 1'b0;
        return m;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input exp_t e);
        int unsigned n = 0;
        bif.in_a = a; bif.in_b = b; bif.in_cin = cin; bif.in_sub = sub;
        bif.in_valid = 1'b1;
        @(negedge clk);
        while (!bif.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bif.in_ready) begin
            check("in_ready_timeout", 32'(bif.in_ready), 32'd1);
        end else begin
            e.acc = cyc;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [15:0] a, b;
        logic        cin, sub;
        a = 16'($urandom); b = 16'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
        send(a, b, cin, sub, model(a, b, cin, sub));
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        while (sbq.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("drain", 32'(sbq.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Downstream readiness generator
    initial begin
        bif.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       bif.out_ready = ($urandom_range(0, 3) != 0);
                2:       bif.out_ready = !((cyc - s0) >= 3 && (cyc - s0) <= 5);
                default: bif.out_ready = 1'b1;
            endcase
        end
    end

    // Output monitor: the head of the scoreboard must be presented every cycle
    // out_valid is high, which also covers stability while stalled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (!bif.in_ready) saw_low = 1'b1;
                if (bif.out_valid) begin
                    if (sbq.size() == 0) begin
                        check("spurious_valid", 32'(bif.out_valid), 32'd0);
                    end else begin
                        e = sbq[0];
                        check("sum",  32'(bif.out_sum),  32'(e.sum));
                        check("cout", 32'(bif.out_cout), 32'(e.cout));
                        check("ovf",  32'(bif.out_ovf),  32'(e.ovf));
                        if (bif.out_ready) begin
                            if (e.latchk) check("latency", cyc - e.acc, 32'd4);
                            void'(sbq.pop_front());
                            pop_cyc.push_back(cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst = 1'b1;
        bif.in_valid = 1'b0; bif.in_a = '0; bif.in_b = '0;
        bif.in_cin = 1'b0; bif.in_sub = 1'b0;
        #1;
        check("rst_out_valid", 32'(bif.out_valid), 32'd0);
        check("rst_out_sum",   32'(bif.out_sum),   32'd0);
        check("rst_out_cout",  32'(bif.out_cout),  32'd0);
        check("rst_out_ovf",   32'(bif.out_ovf),   32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 32'(bif.in_ready), 32'd1);

        // Directed arithmetic cases, first one with latency check
        e = mk(16'h2234, 1'b0, 1'b0);
        e.latchk = 1'b1;
        send(16'h1234, 16'h0FFF, 1'b1, 1'b0, e);
        wait_drain();
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, mk(16'h0000, 1'b1, 1'b0));
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
        send(16'h0005, 16'h0007, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
        send(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
        wait_drain();

        // Back-to-back beats with a three-cycle downstream stall
        saw_low = 1'b0;
        s0 = cyc;
        rdy_mode = 2;
        for (int unsigned i = 0; i < 8; i++) send_rand();
        wait_drain();
        check("in_ready_dropped", 32'(saw_low), 32'd1);
        rdy_mode = 0;

        // Random traffic with random gaps and backpressure
        rdy_mode = 1;
        for (int unsigned i = 0; i < 100; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send_rand();
        end
        wait_drain();
        rdy_mode = 0;
        @(posedge clk);
        #1;

        // Full-rate stretch: 20 results on consecutive cycles
        pop_cyc.delete();
        for (int unsigned i = 0; i < 20; i++) send_rand();
        wait_drain();
        check("rate_count", 32'(pop_cyc.size()), 32'd20);
        if (pop_cyc.size() == 20) check("rate_span", pop_cyc[19] - pop_cyc[0], 32'd19);

        // Reset with three beats in flight
        for (int unsigned i = 0; i < 3; i++) send_rand();
        rst = 1'b1;
        sbq.delete();
        #1;
        check("mid_rst_out_valid", 32'(bif.out_valid), 32'd0);
        check("mid_rst_out_sum",   32'(bif.out_sum),   32'd0);
        check("mid_rst_out_cout",  32'(bif.out_cout),  32'd0);
        check("mid_rst_out_ovf",   32'(bif.out_ovf),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(bif.in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        e = model(16'hA5A5, 16'h5A5B, 1'b0, 1'b0);
        e.latchk = 1'b1;
        send(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, e);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
